// File: rtl/nem_relay_pkg.sv
// Shared types and helpers for the NEM relay select-line driver.
// Holds the controller state encoding, one-hot decode and counter sizing.
package nem_relay_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBreak = 2'd1,
        StMake  = 2'd2
    } relay_state_e;

    localparam int unsigned MaxIn = 64;

    // Indices outside [0, n) decode to all-zero, i.e. every relay open.
    function automatic logic [MaxIn-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MaxIn-1:0] v;
        v = '0;
        if (idx < n && idx < MaxIn) begin
            v[idx[5:0]] = 1'b1;
        end
        return v;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nem_settle_cnt.sv
// Loadable down-counter timing the relay break and make intervals.
// Holds at zero rather than wrapping; the controller reloads it on every state entry.
module nem_settle_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nem_ohmux_sel_drv.sv
// Break-before-make select driver for the NEM one-hot inverting mux cells.
// Opens all relays, waits the release time, closes the target, then waits the settle time.
module nem_ohmux_sel_drv
    import nem_relay_pkg::*;
#(
    parameter int unsigned N_IN      = 2,
    parameter int unsigned BREAK_CYC = 4,
    parameter int unsigned MAKE_CYC  = 8,
    parameter int unsigned SEL_W     = $clog2(N_IN)
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_off,
    output logic [N_IN-1:0]  S,
    output logic             sel_stable,
    output logic             done,
    output logic             err
);

    localparam int unsigned CntW = cnt_width(BREAK_CYC, MAKE_CYC);
    localparam logic [CntW-1:0] BreakLd = CntW'(BREAK_CYC - 1);
    localparam logic [CntW-1:0] MakeLd  = CntW'(MAKE_CYC - 1);

    relay_state_e    state_q, state_d;
    logic [N_IN-1:0] s_q, s_d;
    logic [N_IN-1:0] tgt_q, tgt_d;
    logic            off_q, off_d;
    logic            stable_q, stable_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            cnt_load;
    logic [CntW-1:0] cnt_val;
    logic            cnt_zero;
    logic            sel_oor;
    logic [N_IN-1:0] req_oh;

    assign sel_oor = (32'(req_sel) >= N_IN);
    assign req_oh  = N_IN'(onehot(32'(req_sel), N_IN));

    nem_settle_cnt #(
        .W (CntW)
    ) u_settle_cnt (
        .clk_i      (CP),
        .rst_ni     (CDN),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (state_q != StIdle),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        tgt_d    = tgt_q;
        off_d    = off_q;
        stable_d = stable_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (!req_off && sel_oor) begin
                        err_d = 1'b1;
                    end else if (!req_off && stable_q && s_q == req_oh) begin
                        done_d = 1'b1;
                    end else begin
                        // Break always runs, even from all-open, to keep latency fixed.
                        state_d  = StBreak;
                        s_d      = '0;
                        stable_d = 1'b0;
                        tgt_d    = req_off ? '0 : req_oh;
                        off_d    = req_off;
                        cnt_load = 1'b1;
                        cnt_val  = BreakLd;
                    end
                end
            end
            StBreak: begin
                if (cnt_zero) begin
                    if (off_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StMake;
                        s_d      = tgt_q;
                        cnt_load = 1'b1;
                        cnt_val  = MakeLd;
                    end
                end
            end
            StMake: begin
                if (cnt_zero) begin
                    state_d  = StIdle;
                    stable_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                s_d     = '0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q  <= StIdle;
            s_q      <= '0;
            tgt_q    <= '0;
            off_q    <= 1'b0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            tgt_q    <= tgt_d;
            off_q    <= off_d;
            stable_q <= stable_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Gated by CDN so every output reads 0 while reset is held.
    assign req_ready  = (state_q == StIdle) && CDN;
    assign S          = s_q;
    assign sel_stable = stable_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_drv.sv
// Randomized bench for nem_ohmux_sel_drv against a cycle-timeline reference model.
// Each accepted request writes its expected per-cycle outputs from the documented latencies.
module tb_nem_ohmux_sel_drv;

    localparam int unsigned NIn    = 3;
    localparam int unsigned Brk    = 4;
    localparam int unsigned Mk     = 8;
    localparam int unsigned SelW   = 2;
    localparam int          MaxCyc = 4000;

    logic            CP;
    logic            CDN;
    logic            req_valid;
    logic            req_ready;
    logic [SelW-1:0] req_sel;
    logic            req_off;
    logic [NIn-1:0]  S;
    logic            sel_stable;
    logic            done;
    logic            err;

    nem_ohmux_sel_drv #(
        .N_IN      (NIn),
        .BREAK_CYC (Brk),
        .MAKE_CYC  (Mk),
        .SEL_W     (SelW)
    ) dut (
        .CP         (CP),
        .CDN        (CDN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_off    (req_off),
        .S          (S),
        .sel_stable (sel_stable),
        .done       (done),
        .err        (err)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int cyc = 0;
    always @(posedge CP) cyc <= cyc + 1;

    // Expected outputs indexed by cycle number.
    logic [NIn-1:0] exp_s      [MaxCyc];
    bit             exp_stable [MaxCyc];
    bit             exp_ready  [MaxCyc];
    bit             exp_done   [MaxCyc];
    bit             exp_err    [MaxCyc];

    int n_checks = 0;
    int n_errors = 0;
    bit in_rst   = 1'b1;
    bit last_acc = 1'b0;
    int n_acc    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic fill(input int from, input logic [NIn-1:0] s, input bit st, input bit rdy);
        for (int i = from; i < MaxCyc; i++) begin
            exp_s[i]      = s;
            exp_stable[i] = st;
            exp_ready[i]  = rdy;
            exp_done[i]   = 1'b0;
            exp_err[i]    = 1'b0;
        end
    endtask

    // Request accepted in cycle k: outputs from cycle k+1 onward follow the latency rules.
    task automatic accept(input int k, input logic [SelW-1:0] sel, input bit off);
        logic [NIn-1:0] oh;
        oh = (int'(sel) < NIn) ? NIn'(1 << sel) : '0;
        n_acc++;
        if (off) begin
            fill(k + 1, '0, 1'b0, 1'b0);
            fill(k + 1 + Brk, '0, 1'b0, 1'b1);
            exp_done[k + 1 + Brk] = 1'b1;
        end else if (int'(sel) >= NIn) begin
            exp_err[k + 1] = 1'b1;
        end else if (exp_stable[k] && exp_s[k] == oh) begin
            exp_done[k + 1] = 1'b1;
        end else begin
            fill(k + 1, '0, 1'b0, 1'b0);
            fill(k + 1 + Brk, oh, 1'b0, 1'b0);
            fill(k + 1 + Brk + Mk, oh, 1'b1, 1'b1);
            exp_done[k + 1 + Brk + Mk] = 1'b1;
        end
    endtask

    task automatic check_cycle(input int k);
        check_val("S", 32'(S), 32'(exp_s[k]));
        check_val("sel_stable", 32'(sel_stable), 32'(exp_stable[k]));
        check_val("done", 32'(done), 32'(exp_done[k]));
        check_val("err", 32'(err), 32'(exp_err[k]));
        check_val("req_ready", 32'(req_ready), 32'(exp_ready[k]));
        check_val("onehot_or_zero", 32'($countones(S) <= 1), 32'd1);
    endtask

    task automatic step(input bit v, input logic [SelW-1:0] sel, input bit off);
        int k;
        @(negedge CP);
        k = cyc;
        if (!in_rst) check_cycle(k);
        req_valid = v;
        req_sel   = sel;
        req_off   = off;
        last_acc  = v && CDN && !in_rst && exp_ready[k];
        if (last_acc) accept(k, sel, off);
    endtask

    task automatic do_req(input logic [SelW-1:0] sel, input bit off);
        int n;
        n = 0;
        do begin
            step(1'b1, sel, off);
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) check_val("accept_timeout", 32'd0, 32'd1);
        repeat (Brk + Mk + 2) step(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_S"}, 32'(S), 32'd0);
        check_val({tag, "_stable"}, 32'(sel_stable), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
        check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic [SelW-1:0] alt;
        int k0;
        req_valid = 1'b0;
        req_sel   = '0;
        req_off   = 1'b0;
        CDN       = 1'b0;
        fill(0, '0, 1'b0, 1'b1);
        #3;
        check_reset_outputs("rst");
        repeat (2) step(1'b0, '0, 1'b0);
        CDN = 1'b1;
        fill(cyc, '0, 1'b0, 1'b1);
        in_rst = 1'b0;

        do_req(2'd1, 1'b0);   // 000 -> 010
        do_req(2'd0, 1'b0);   // 010 -> 000 -> 001
        do_req(2'd0, 1'b0);   // same select while stable
        do_req(2'd0, 1'b1);   // all relays open
        do_req(2'd3, 1'b0);   // out-of-range index
        do_req(2'd2, 1'b0);

        // Abort during the third MAKE cycle.
        do begin
            step(1'b1, 2'd1, 1'b0);
        end while (!last_acc && cyc < 200);
        k0 = cyc;
        while (cyc < k0 + 1 + Brk + 2) step(1'b0, '0, 1'b0);
        check_val("pre_abort_S", 32'(S), 32'(3'b010));
        #2 CDN = 1'b0;
        in_rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (3) step(1'b0, '0, 1'b0);
        check_reset_outputs("abort_hold");
        CDN = 1'b1;
        fill(cyc, '0, 1'b0, 1'b1);
        in_rst = 1'b0;
        do_req(2'd0, 1'b0);

        // Valid held high with alternating select: back-to-back acceptance.
        alt = 2'd1;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, alt, 1'b0);
            if (last_acc) alt = (alt == 2'd1) ? 2'd0 : 2'd1;
        end

        for (int i = 0; i < 1600; i++) begin
            step($urandom_range(0, 2) != 0, SelW'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0);
        end
        repeat (Brk + Mk + 2) step(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #((MaxCyc - 100) * 10);
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
